// File: rtl/prio_event_fifo.sv
// ---------------------------------------------------------------------------
// prio_event_fifo
//
// Turns the output of an upstream priority encoder into a stream of
// timestamped "events" and queues them in a small show-ahead FIFO.
// An event is a change of the encoded index while the stage is enabled.
// Each event carries the index and the value of a free-running 8-bit
// timestamp.
//
// Ports
//   clk        system clock, all state changes on its rising edge
//   rst        synchronous active-high reset
//   en         stage enable: gates event capture and timestamp counting
//   code_in    encoder output, 0x00-0x0F = index, anything else = none
//   pop        consumer acknowledge, removes the head entry if one exists
//   out_valid  FIFO holds at least one entry
//   out_code   head entry index (0 when empty)
//   out_stamp  head entry timestamp (0 when empty)
//   count      current occupancy, 0..DEPTH
//   overflow   sticky: at least one event was dropped since reset
//   drop_cnt   number of dropped events, saturating at 0xF
// ---------------------------------------------------------------------------
module prio_event_fifo #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] code_in,
    input  logic       pop,
    output logic       out_valid,
    output logic [3:0] out_code,
    output logic [7:0] out_stamp,
    output logic [2:0] count,
    output logic       overflow,
    output logic [3:0] drop_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [3:0]       mem_code  [DEPTH];
    logic [7:0]       mem_stamp [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [7:0]       prev_code;
    logic [7:0]       tstamp;

    logic code_valid;
    logic evt_hit;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;
    logic do_drop;

    // Pointers wrap modulo DEPTH, so non-power-of-two depths also work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Event detection and push/pop/drop decisions.
    // When full, a same-edge pop frees the slot the new event lands in
    // (wr_ptr equals rd_ptr), so push and pop can both proceed without a drop.
    always_comb begin
        code_valid = (code_in[7:4] == 4'h0);
        evt_hit    = en && code_valid && (code_in != prev_code);
        empty      = (count == 3'd0);
        full       = (count == 3'(DEPTH));
        do_pop     = pop && !empty;
        do_push    = evt_hit && (!full || do_pop);
        do_drop    = evt_hit && full && !do_pop;
    end

    // Edge detector, timestamp, FIFO storage and drop bookkeeping.
    // prev_code tracks raw code_in (including "none" values), which is what
    // makes none-then-same-index count as a fresh event.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_code <= 8'hF0;
            tstamp    <= 8'h00;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= 3'd0;
            overflow  <= 1'b0;
            drop_cnt  <= 4'h0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_code[i]  <= 4'h0;
                mem_stamp[i] <= 8'h00;
            end
        end else begin
            if (en) begin
                prev_code <= code_in;
                tstamp    <= tstamp + 8'd1;
            end

            if (do_push) begin
                mem_code[wr_ptr]  <= code_in[3:0];
                mem_stamp[wr_ptr] <= tstamp;
                wr_ptr            <= ptr_inc(wr_ptr);
            end

            if (do_pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end

            case ({do_push, do_pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase

            if (do_drop) begin
                overflow <= 1'b1;
                if (drop_cnt != 4'hF) begin
                    drop_cnt <= drop_cnt + 4'd1;
                end
            end
        end
    end

    // Show-ahead head presentation; forced to zero when empty so stale
    // storage never leaks onto the outputs.
    always_comb begin
        out_valid = !empty;
        out_code  = empty ? 4'h0  : mem_code[rd_ptr];
        out_stamp = empty ? 8'h00 : mem_stamp[rd_ptr];
    end

endmodule

// File: tb/tb_prio_event_fifo.sv
// ---------------------------------------------------------------------------
// tb_prio_event_fifo
//
// Directed testbench for prio_event_fifo. A queue-based reference model
// tracks the expected FIFO contents, timestamp, overflow and drop count;
// a compare process checks every DUT output against it on each falling
// edge, and literal checks pin key expected values by hand.
// ---------------------------------------------------------------------------
module tb_prio_event_fifo;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] code_in;
    logic       pop;
    logic       out_valid;
    logic [3:0] out_code;
    logic [7:0] out_stamp;
    logic [2:0] count;
    logic       overflow;
    logic [3:0] drop_cnt;

    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;

    typedef struct {
        logic [3:0] code;
        logic [7:0] stamp;
    } entry_t;

    entry_t     mq[$];
    logic [7:0] m_prev = 8'hF0;
    logic [7:0] m_ts   = 8'h00;
    logic       m_ovf  = 1'b0;
    logic [3:0] m_drop = 4'h0;

    prio_event_fifo #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .code_in   (code_in),
        .pop       (pop),
        .out_valid (out_valid),
        .out_code  (out_code),
        .out_stamp (out_stamp),
        .count     (count),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point shared by model and literal checks.
    task automatic compareValue(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one clock edge worth of behaviour from the
    // current inputs, expressed as queue operations.
    task automatic modelStep();
        entry_t e;
        bit     popped;
        bit     hit;
        int     pre;
        if (rst) begin
            mq.delete();
            m_prev = 8'hF0;
            m_ts   = 8'h00;
            m_ovf  = 1'b0;
            m_drop = 4'h0;
        end else begin
            pre    = mq.size();
            popped = pop && (pre > 0);
            hit    = en && (code_in[7:4] == 4'h0) && (code_in != m_prev);
            if (popped) void'(mq.pop_front());
            if (hit) begin
                if (pre < 4 || popped) begin
                    e.code  = code_in[3:0];
                    e.stamp = m_ts;
                    mq.push_back(e);
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop != 4'hF) m_drop = m_drop + 4'd1;
                end
            end
            if (en) begin
                m_prev = code_in;
                m_ts   = m_ts + 8'd1;
            end
        end
    endtask

    // Model-versus-DUT comparison of every output.
    task automatic checkOutput();
        logic [3:0] ec;
        logic [7:0] es;
        ec = (mq.size() > 0) ? mq[0].code  : 4'h0;
        es = (mq.size() > 0) ? mq[0].stamp : 8'h00;
        compareValue("out_valid", {7'b0, out_valid}, {7'b0, mq.size() != 0});
        compareValue("out_code",  {4'b0, out_code},  {4'b0, ec});
        compareValue("out_stamp", out_stamp, es);
        compareValue("count",     {5'b0, count},     8'(mq.size()));
        compareValue("overflow",  {7'b0, overflow},  {7'b0, m_ovf});
        compareValue("drop_cnt",  {4'b0, drop_cnt},  {4'b0, m_drop});
    endtask

    always @(negedge clk) begin
        if (check_en) checkOutput();
    end

    task automatic checkLiteral(input string name, input logic [7:0] act, input logic [7:0] exp);
        compareValue(name, act, exp);
    endtask

    // Drive one cycle of inputs, advance model at the edge, return at the
    // following falling edge with outputs settled.
    task automatic applyStimulus(input logic r, input logic e, input logic [7:0] c, input logic p);
        rst     = r;
        en      = e;
        code_in = c;
        pop     = p;
        @(posedge clk);
        modelStep();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; code_in = 8'hF0; pop = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 1'b0, 8'hF0, 1'b0);
        check_en = 1'b1;

        // Reset dominates en/pop/code_in
        $display("[TB] reset state");
        applyStimulus(1'b1, 1'b1, 8'h05, 1'b1);
        checkLiteral("rst_count",     {5'b0, count},     8'h00);
        checkLiteral("rst_out_valid", {7'b0, out_valid}, 8'h00);
        checkLiteral("rst_out_stamp", out_stamp,         8'h00);

        // Stable code gives a single event
        $display("[TB] stable code");
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 8'h0D, 1'b0);
        checkLiteral("stable_code",  {4'b0, out_code}, 8'h0D);
        checkLiteral("stable_stamp", out_stamp,        8'h00);
        checkLiteral("stable_count", {5'b0, count},    8'h01);

        // None then same index re-triggers
        $display("[TB] none and back");
        applyStimulus(1'b1, 1'b0, 8'hF0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h0D, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h0D, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h0F, 1'b0);
        checkLiteral("seq_count", {5'b0, count}, 8'h03);
        checkLiteral("seq_head0", out_stamp,     8'h00);
        applyStimulus(1'b0, 1'b0, 8'h0F, 1'b1);
        checkLiteral("seq_head1_code",  {4'b0, out_code}, 8'h0D);
        checkLiteral("seq_head1_stamp", out_stamp,        8'h02);
        applyStimulus(1'b0, 1'b0, 8'h0F, 1'b1);
        checkLiteral("seq_head2_code",  {4'b0, out_code}, 8'h0F);
        checkLiteral("seq_head2_stamp", out_stamp,        8'h03);
        applyStimulus(1'b0, 1'b0, 8'h0F, 1'b1);
        checkLiteral("seq_empty_code", {4'b0, out_code}, 8'h00);

        // Overflow, drop counter saturation and ordered drain
        $display("[TB] overflow");
        applyStimulus(1'b1, 1'b0, 8'hF0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
        checkLiteral("ovf_count", {5'b0, count},    8'h04);
        checkLiteral("ovf_head",  {4'b0, out_code}, 8'h00);
        checkLiteral("ovf_flag",  {7'b0, overflow}, 8'h01);
        checkLiteral("ovf_drops", {4'b0, drop_cnt}, 8'h01);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, (i % 2 == 0) ? 8'h05 : 8'h06, 1'b0);
        checkLiteral("drop_sat", {4'b0, drop_cnt}, 8'h0F);
        for (int i = 0; i < 4; i++) begin
            checkLiteral("drain_order", {4'b0, out_code}, 8'(i));
            applyStimulus(1'b0, 1'b0, 8'hF0, 1'b1);
        end
        checkLiteral("drain_count",  {5'b0, count},    8'h00);
        checkLiteral("ovf_sticky",   {7'b0, overflow}, 8'h01);

        // Full with simultaneous push and pop
        $display("[TB] full push+pop");
        applyStimulus(1'b1, 1'b0, 8'hF0, 1'b0);
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 1'b1, 8'(i), 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h0E, 1'b1);
        checkLiteral("fpp_count", {5'b0, count},    8'h04);
        checkLiteral("fpp_ovf",   {7'b0, overflow}, 8'h00);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 8'hF0, 1'b1);
        checkLiteral("fpp_tail_code",  {4'b0, out_code}, 8'h0E);
        checkLiteral("fpp_tail_stamp", out_stamp,        8'h04);

        // Disabled stage, pop on empty, held prev_code
        $display("[TB] enable gating");
        applyStimulus(1'b1, 1'b0, 8'hF0, 1'b0);
        for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, (i % 2 == 0) ? 8'h01 : 8'h02, 1'b1);
        checkLiteral("dis_count", {5'b0, count}, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b1);
        checkLiteral("dis_stamp", out_stamp,     8'h00);
        checkLiteral("dis_push",  {5'b0, count}, 8'h01);
        applyStimulus(1'b0, 1'b0, 8'h07, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h07, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b0);
        checkLiteral("hold_prev", {5'b0, count}, 8'h01);
        applyStimulus(1'b0, 1'b1, 8'h06, 1'b1);
        checkLiteral("pp_count", {5'b0, count},    8'h01);
        checkLiteral("pp_code",  {4'b0, out_code}, 8'h06);
        checkLiteral("pp_stamp", out_stamp,        8'h02);

        // Timestamp wrap and mid-operation reset
        $display("[TB] wrap and reset");
        applyStimulus(1'b1, 1'b0, 8'hF0, 1'b0);
        for (int i = 0; i < 258; i++) applyStimulus(1'b0, 1'b1, 8'hF0, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h03, 1'b0);
        checkLiteral("wrap_stamp", out_stamp, 8'h02);
        applyStimulus(1'b0, 1'b1, 8'h04, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h05, 1'b0);
        checkLiteral("pre_rst_count", {5'b0, count}, 8'h03);
        applyStimulus(1'b1, 1'b1, 8'h06, 1'b1);
        checkLiteral("mid_rst_count", {5'b0, count},     8'h00);
        checkLiteral("mid_rst_ovf",   {7'b0, overflow},  8'h00);
        checkLiteral("mid_rst_valid", {7'b0, out_valid}, 8'h00);
        applyStimulus(1'b0, 1'b1, 8'h03, 1'b0);
        checkLiteral("post_rst_stamp", out_stamp,        8'h00);
        checkLiteral("post_rst_code",  {4'b0, out_code}, 8'h03);

        check_en = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/prio_event_fifo.md
PRIO_EVENT_FIFO -- requirements
Module: prio_event_fifo

Interface
REQ-001 SHALL have one clock and one reset: clock `clk`, reset `rst`; reset synchronous, active-high; all state updates on rising edge of clk only.
REQ-002 SHALL expose DEPTH parameter, default 4, meaning the event FIFO entry count; only value 4 is required to be supported.
REQ-003 clk  input  1  system clock.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 en  input  1  stage enable; gates event capture and timestamp counting.
REQ-006 code_in  input  8  upstream priority-encoder output: 0x00-0x0F = index of highest set request bit; 0xF0 = no bit set.
REQ-007 pop  input  1  consumer acknowledge; removes head entry when out_valid=1.
REQ-008 out_valid  output  1  FIFO non-empty.
REQ-009 out_code  output  4  head entry index.
REQ-010 out_stamp  output  8  head entry timestamp.
REQ-011 count  output  3  current occupancy, 0-4.
REQ-012 overflow  output  1  sticky flag: an event was dropped.
REQ-013 drop_cnt  output  4  number of dropped events, saturating.

Function
REQ-014 code_in SHALL be "valid" when code_in[7:4]==0; any other value, including 0xF0, SHALL be treated as "none".
REQ-015 SHALL hold prev_code (8 bit, reset 0xF0); on every edge with en=1, prev_code <= code_in; with en=0, prev_code holds.
REQ-016 An event SHALL be detected on an edge where en=1, code_in valid, and code_in != prev_code; a stable code generates exactly one event.
REQ-017 A transition to "none" and back to the same index SHALL generate a new event.
REQ-018 SHALL keep 8-bit timestamp counter tstamp (reset 0x00), incremented on each edge with en=1, wrapping 0xFF->0x00; holds when en=0.
REQ-019 An event SHALL push {code_in[3:0], tstamp value before increment} into the FIFO.
REQ-020 FIFO SHALL be show-ahead: out_valid = (count!=0); out_code/out_stamp present the head entry combinationally from registers; both SHALL read 0 when empty.
REQ-021 Latency: event detected at edge N into empty FIFO SHALL make out_valid=1 and head visible immediately after edge N.
REQ-022 pop with out_valid=1 SHALL remove the head at the edge; pop with out_valid=0 SHALL be ignored without state change.
REQ-023 pop SHALL be honoured regardless of en.
REQ-024 Simultaneous push and pop SHALL both occur; count unchanged; when empty, no simultaneous pop occurs (pop ignored, push proceeds).
REQ-025 Full (count=4) with push and pop on same edge: both occur, no drop, overflow unchanged.
REQ-026 Full with push and no pop: event dropped, FIFO unchanged, overflow <= 1, drop_cnt increments saturating at 0xF.
REQ-027 Entries SHALL leave in arrival order; read/write pointers wrap modulo DEPTH.
REQ-028 overflow and drop_cnt SHALL clear only on reset.

Reset
REQ-029 With rst=1 at an edge, all state SHALL reset regardless of en, pop, code_in: count=0, out_valid=0, out_code=0, out_stamp=0x00, overflow=0, drop_cnt=0, tstamp=0x00, prev_code=0xF0.
REQ-030 Reset mid-operation SHALL discard all FIFO contents; first edge after release with en=1 and valid code_in SHALL produce an event stamped 0x00.

Verification
REQ-031 Reset, en=1, code_in=0x0D held 3 cycles -> exactly one entry, out_code=0xD, out_stamp=0x00, count=1.
REQ-032 code_in sequence 0x0D,0xF0,0x0D,0x0F (one cycle each, no pop) -> entries (0xD,0x00),(0xD,0x02),(0xF,0x03), count=3.
REQ-033 Five distinct codes 0x00..0x04 on consecutive cycles, no pop -> count=4, head 0x0, overflow=1, drop_cnt=1; four pops return 0x0,0x1,0x2,0x3 in order.
REQ-034 FIFO full, new code 0x0E with pop=1 on same edge -> count stays 4, overflow stays 0, tail=0xE.
REQ-035 en=0 while code_in toggles 0x01/0x02 for 10 cycles -> no events, tstamp frozen; pop on empty FIFO -> count stays 0.
REQ-036 Run 258 enabled cycles then new code -> stamp 0x02 (wrap); assert rst with count=3 -> next edge count=0, overflow=0, out_valid=0.
